// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl
// Trigger and capture sequencer for the oscilloscope display path.
// It decimates the ADC stream and waits for a trigger crossing, or for an
// auto-mode timeout. It then writes one DEPTH-sample record into a
// double-buffered RAM. Banks swap only on a vblank rising edge, so the
// renderer never reads a half-written record.
//
// Ports:
//   clk50, reset_n          : 50 MHz clock, asynchronous active-low reset
//   run, single, mode_auto  : acquisition control (level / pulse / auto mode)
//   trig_rising, trig_level : trigger edge select and unsigned threshold
//   decim                   : keep 1 of 2^decim valid samples (clamped to 10)
//   sample_valid, sample    : ADC sample stream
//   vblank                  : vertical blank level
//   wr_en/wr_addr/wr_data   : registered RAM write port
//   wr_bank, rd_bank        : bank being written / bank being displayed
//   triggered               : last displayed record started on a real trigger
//   busy                    : state is not IDLE
//   frame_cnt               : completed bank swaps, wraps at 0xFFFF
module scope_capture_ctrl #(
    parameter int SAMPLE_W     = 12,
    parameter int DEPTH        = 800,
    parameter int ADDR_W       = 10,
    parameter int AUTO_TIMEOUT = 1000000
) (
    input  logic                clk50,
    input  logic                reset_n,
    input  logic                run,
    input  logic                single,
    input  logic                mode_auto,
    input  logic                trig_rising,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic [3:0]          decim,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                vblank,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SAMPLE_W-1:0] wr_data,
    output logic                wr_bank,
    output logic                rd_bank,
    output logic                triggered,
    output logic                busy,
    output logic [15:0]         frame_cnt
);

    localparam int TO_W = $clog2(AUTO_TIMEOUT) + 1;
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [9:0]          dcnt_r;
    logic [SAMPLE_W-1:0] prev_r;
    logic                prev_ok_r;
    logic [TO_W-1:0]     tcnt_r;
    logic [ADDR_W-1:0]   cnt_r;
    logic                one_shot_r;
    logic                trig_flag_r;
    logic                vblank_q_r;

    logic                wr_en_r, wr_bank_r, rd_bank_r, triggered_r, busy_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [SAMPLE_W-1:0] wr_data_r;
    logic [15:0]         frame_cnt_r;

    logic [3:0]          decim_c_s;
    logic [9:0]          dmask_s;
    logic                accept_s, trig_s, force_s, vb_rise_s, enter_armed_s;
    logic                wr_en_s, swap_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [SAMPLE_W-1:0] wr_data_s;

    assign decim_c_s     = (decim > 4'd10) ? 4'd10 : decim;
    assign dmask_s       = 10'((11'd1 << decim_c_s) - 11'd1);
    assign accept_s      = sample_valid && (dcnt_r == 10'd0);
    assign vb_rise_s     = vblank && !vblank_q_r;
    // Auto mode forces the first accepted sample once the timeout has elapsed.
    assign force_s       = mode_auto && (tcnt_r == TO_LAST) && accept_s;
    assign enter_armed_s = (state_nxt_s == ST_ARMED) && (state_r != ST_ARMED);

    // Trigger crossing on an accepted sample; needs a valid previous sample.
    always_comb begin
        trig_s = 1'b0;
        if (accept_s && prev_ok_r) begin
            if (trig_rising) begin
                trig_s = (prev_r < trig_level) && (sample >= trig_level);
            end else begin
                trig_s = (prev_r > trig_level) && (sample <= trig_level);
            end
        end else begin
            trig_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; leaving ARMED for IDLE has priority over a trigger.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run || single) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!run && !one_shot_r) begin
                    state_nxt_s = ST_IDLE;
                end else if (trig_s || force_s) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (accept_s && (cnt_r == LAST_ADDR)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                if (vb_rise_s) begin
                    state_nxt_s = (run && !one_shot_r) ? ST_ARMED : ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: next values for the write port and the bank-swap strobe.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        swap_s    = 1'b0;
        case (state_r)
            ST_ARMED: begin
                if (state_nxt_s == ST_CAPTURE) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = '0;
                    wr_data_s = sample;
                end else begin
                    wr_en_s   = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (accept_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cnt_r;
                    wr_data_s = sample;
                end else begin
                    wr_en_s   = 1'b0;
                end
            end
            ST_DONE: swap_s = vb_rise_s;
            default: swap_s = 1'b0;
        endcase
    end

    // Decimator, trigger history, timeout and capture-address counters.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            dcnt_r      <= 10'd0;
            prev_r      <= '0;
            prev_ok_r   <= 1'b0;
            tcnt_r      <= '0;
            cnt_r       <= '0;
            one_shot_r  <= 1'b0;
            trig_flag_r <= 1'b0;
            vblank_q_r  <= 1'b0;
        end else begin
            vblank_q_r <= vblank;
            if (enter_armed_s) begin
                dcnt_r <= 10'd0;
            end else if (sample_valid) begin
                dcnt_r <= (dcnt_r >= dmask_s) ? 10'd0 : dcnt_r + 10'd1;
            end
            if (accept_s) begin
                prev_r <= sample;
            end
            if (enter_armed_s) begin
                prev_ok_r <= 1'b0;
            end else if (accept_s) begin
                prev_ok_r <= 1'b1;
            end
            // Saturates at the last count so the forced capture stays pending.
            if (enter_armed_s) begin
                tcnt_r <= '0;
            end else if ((state_r == ST_ARMED) && (tcnt_r != TO_LAST)) begin
                tcnt_r <= tcnt_r + TO_W'(1);
            end
            // cnt_r holds the address of the next write.
            if ((state_r == ST_ARMED) && (state_nxt_s == ST_CAPTURE)) begin
                cnt_r       <= ADDR_W'(1);
                trig_flag_r <= trig_s;
            end else if ((state_r == ST_CAPTURE) && accept_s) begin
                cnt_r <= cnt_r + ADDR_W'(1);
            end
            if ((state_r == ST_IDLE) && single) begin
                one_shot_r <= 1'b1;
            end else if (swap_s) begin
                one_shot_r <= 1'b0;
            end
        end
    end

    // Registered outputs: write port, banks, status and frame counter.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            wr_bank_r   <= 1'b0;
            rd_bank_r   <= 1'b1;
            triggered_r <= 1'b0;
            busy_r      <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            wr_en_r   <= wr_en_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            if (swap_s) begin
                wr_bank_r   <= ~wr_bank_r;
                rd_bank_r   <= ~rd_bank_r;
                triggered_r <= trig_flag_r;
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
        end
    end

    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign wr_bank   = wr_bank_r;
    assign rd_bank   = rd_bank_r;
    assign triggered = triggered_r;
    assign busy      = busy_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Self-checking bench for scope_capture_ctrl: table-driven trigger/decimation
// records with a write scoreboard, plus hand-written auto, single-shot and
// reset sequences.
module tb_scope_capture_ctrl;

    localparam int SW    = 12;
    localparam int DEPTH = 800;
    localparam int AW    = 10;
    localparam int ATO   = 50;

    logic          clk50, reset_n, run, single, mode_auto, trig_rising;
    logic [SW-1:0] trig_level, sample, wr_data;
    logic [3:0]    decim;
    logic          sample_valid, vblank, wr_en, wr_bank, rd_bank, triggered, busy;
    logic [AW-1:0] wr_addr;
    logic [15:0]   frame_cnt;

    scope_capture_ctrl #(
        .SAMPLE_W(SW), .DEPTH(DEPTH), .ADDR_W(AW), .AUTO_TIMEOUT(ATO)
    ) dut (
        .clk50(clk50), .reset_n(reset_n), .run(run), .single(single),
        .mode_auto(mode_auto), .trig_rising(trig_rising), .trig_level(trig_level),
        .decim(decim), .sample_valid(sample_valid), .sample(sample), .vblank(vblank),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank),
        .rd_bank(rd_bank), .triggered(triggered), .busy(busy), .frame_cnt(frame_cnt)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    typedef struct {
        logic [AW-1:0] addr;
        logic [SW-1:0] data;
    } wr_t;

    typedef struct {
        logic       rising;
        logic [3:0] dec;
        int         level;
        int         start;
        int         step;
        int         exp_first;
        int         exp_delta;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[3];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_count = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every write is compared against the oldest expected write.
    wr_t got_e;
    always @(negedge clk50) begin
        if (reset_n && wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0d, none expected", wr_addr, wr_data);
            end else begin
                got_e = exp_q.pop_front();
                check("wr_addr", longint'(wr_addr), longint'(got_e.addr));
                check("wr_data", longint'(wr_data), longint'(got_e.data));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset_n      = 1'b0;
        run          = 1'b0;
        single       = 1'b0;
        mode_auto    = 1'b0;
        trig_rising  = 1'b1;
        trig_level   = 12'd0;
        decim        = 4'd0;
        sample_valid = 1'b0;
        sample       = 12'd0;
        vblank       = 1'b0;
        repeat (2) @(posedge clk50);
        #1;
        exp_q.delete();
        wr_count = 0;
        reset_n  = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_wr_en"},     longint'(wr_en),     0);
        check({tag, "_wr_addr"},   longint'(wr_addr),   0);
        check({tag, "_wr_data"},   longint'(wr_data),   0);
        check({tag, "_wr_bank"},   longint'(wr_bank),   0);
        check({tag, "_rd_bank"},   longint'(rd_bank),   1);
        check({tag, "_triggered"}, longint'(triggered), 0);
        check({tag, "_busy"},      longint'(busy),      0);
        check({tag, "_frame_cnt"}, longint'(frame_cnt), 0);
    endtask

    task automatic push_expected(input int first, input int delta, input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = AW'(i);
            e.data = SW'(first + delta * i);
            exp_q.push_back(e);
        end
    endtask

    // Drives a ramp (valid every cycle) until `target` writes are seen, then
    // `extra` more samples; pulses single when the sample index equals single_at.
    task automatic drive_ramp(input int start, input int step, input int target,
                              input int extra, input int single_at);
        int v;
        int k;
        v = start;
        k = 0;
        sample_valid = 1'b1;
        while (wr_count < target && k < 6000) begin
            sample = SW'(v);
            single = (k == single_at);
            @(posedge clk50);
            #1;
            v += step;
            k++;
        end
        single = 1'b0;
        if (k >= 6000) begin
            n_checks++;
            n_fail++;
            $display("FAIL capture_timeout: %0d writes, expected %0d", wr_count, target);
        end
        for (int j = 0; j < extra; j++) begin
            sample = SW'(v);
            @(posedge clk50);
            #1;
            v += step;
        end
        sample_valid = 1'b0;
    endtask

    task automatic finish_record(input string tag);
        check({tag, "_write_count"}, wr_count, DEPTH);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_busy_done"}, longint'(busy), 1);
    endtask

    // vblank is high on entry; banks must only move one cycle after a new edge.
    task automatic swap_check(input string tag, input logic exp_trig);
        @(negedge clk50);
        check({tag, "_frame_while_high"}, longint'(frame_cnt), 0);
        check({tag, "_bank_while_high"}, longint'(wr_bank), 0);
        @(posedge clk50); #1; vblank = 1'b0;
        @(posedge clk50); #1; vblank = 1'b1;
        @(negedge clk50);
        check({tag, "_bank_at_edge"}, longint'(wr_bank), 0);
        @(negedge clk50);
        check({tag, "_wr_bank"}, longint'(wr_bank), 1);
        check({tag, "_rd_bank"}, longint'(rd_bank), 0);
        check({tag, "_frame_cnt"}, longint'(frame_cnt), 1);
        check({tag, "_triggered"}, longint'(triggered), longint'(exp_trig));
        check({tag, "_busy_idle"}, longint'(busy), 0);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{rising: 1'b1, dec: 4'd0, level: 2048, start: 2000, step:  1, exp_first: 2048, exp_delta:  1};
        vecs[1] = '{rising: 1'b0, dec: 4'd2, level: 3500, start: 3900, step: -1, exp_first: 3500, exp_delta: -4};
        vecs[2] = '{rising: 1'b1, dec: 4'd1, level: 1000, start:  901, step:  1, exp_first: 1001, exp_delta:  2};

        do_reset();
        check_reset("reset");

        // Table-driven trigger / decimation records, each ending with a swap.
        for (int v = 0; v < 3; v++) begin
            do_reset();
            trig_rising = vecs[v].rising;
            decim       = vecs[v].dec;
            trig_level  = SW'(vecs[v].level);
            vblank      = 1'b1;
            push_expected(vecs[v].exp_first, vecs[v].exp_delta, DEPTH);
            run = 1'b1;
            @(posedge clk50); #1;
            drive_ramp(vecs[v].start, vecs[v].step, DEPTH, 8, -1);
            finish_record($sformatf("vec%0d", v));
            run = 1'b0;
            swap_check($sformatf("vec%0d", v), 1'b1);
        end

        // Auto mode: constant input, forced capture exactly ATO cycles after arming.
        do_reset();
        mode_auto   = 1'b1;
        trig_level  = 12'd2048;
        vblank      = 1'b1;
        push_expected(100, 0, DEPTH);
        run          = 1'b1;
        sample       = 12'd100;
        sample_valid = 1'b1;
        @(negedge clk50);
        while (!busy) @(negedge clk50);
        cyc = 0;
        while (!wr_en && cyc < 200) begin
            @(negedge clk50);
            cyc++;
        end
        check("auto_start_cycles", cyc, ATO);
        @(posedge clk50); #1;
        drive_ramp(100, 0, DEPTH, 8, -1);
        finish_record("auto");
        run = 1'b0;
        mode_auto = 1'b0;
        swap_check("auto", 1'b0);

        // Single shot with run low; a second pulse mid-capture is ignored.
        do_reset();
        trig_level = 12'd2048;
        vblank     = 1'b1;
        push_expected(2048, 1, DEPTH);
        single = 1'b1;
        @(posedge clk50); #1;
        single = 1'b0;
        drive_ramp(2000, 1, DEPTH, 8, 400);
        finish_record("single");
        swap_check("single", 1'b1);
        drive_ramp(2000, 1, 0, 80, -1);
        check("single_no_rearm_writes", wr_count, DEPTH);
        check("single_idle_busy", longint'(busy), 0);

        // Reset in the middle of a record.
        do_reset();
        trig_level = 12'd2048;
        vblank     = 1'b1;
        push_expected(2048, 1, DEPTH);
        run = 1'b1;
        @(posedge clk50); #1;
        drive_ramp(2000, 1, 401, 0, -1);
        #3 reset_n = 1'b0;
        #1 check_reset("midreset");
        run = 1'b0;
        repeat (2) @(posedge clk50);
        #1;
        exp_q.delete();
        wr_count = 0;
        reset_n  = 1'b1;
        drive_ramp(2000, 1, 0, 100, -1);
        check("post_reset_idle_writes", wr_count, 0);
        check("post_reset_idle_busy", longint'(busy), 0);
        run = 1'b1;
        @(posedge clk50); #1;
        drive_ramp(3000, 0, 0, 100, -1);
        check("armed_no_trigger_writes", wr_count, 0);
        check("armed_busy", longint'(busy), 1);
        push_expected(2048, 1, DEPTH);
        drive_ramp(2000, 1, DEPTH, 8, -1);
        finish_record("rearm");
        run = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
